// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite response codes, Timer0 register map and write-lane helpers.
package axi_lite_pkg;

  localparam int unsigned REG_W        = 64;
  localparam int unsigned STRB_W       = 4;
  localparam int unsigned STRB_LANE_W  = 16;
  localparam int unsigned IDX_W        = 9;

  localparam logic [2:0] RESP_OKAY   = 3'b000;
  localparam logic [2:0] RESP_SLVERR = 3'b010;

  localparam logic [IDX_W-1:0] TIMER_CTRL   = 9'd0;
  localparam logic [IDX_W-1:0] TIMER_COUNT  = 9'd1;
  localparam logic [IDX_W-1:0] TIMER_CMP    = 9'd2;
  localparam logic [IDX_W-1:0] TIMER_STATUS = 9'd3;

  localparam int unsigned CTRL_EN_BIT     = 0;
  localparam int unsigned CTRL_AUTO_BIT   = 1;
  localparam int unsigned CTRL_IRQ_EN_BIT = 2;
  localparam int unsigned CTRL_PRESC_LSB  = 8;
  localparam int unsigned CTRL_PRESC_W    = 8;

  // Register write request from the bus front end to the timer core.
  typedef struct packed {
    logic             en;
    logic [1:0]       idx;
    logic [REG_W-1:0] data;
    logic [STRB_W-1:0] strb;
  } timer_wr_t;

  // Merge new data into an old register value, one 16-bit lane per strobe bit.
  function automatic logic [REG_W-1:0] lane_merge(input logic [REG_W-1:0] old_val,
                                                  input logic [REG_W-1:0] new_val,
                                                  input logic [STRB_W-1:0] strb);
    logic [REG_W-1:0] mask;
    for (int i = 0; i < int'(STRB_W); i++) begin
      mask[i*STRB_LANE_W +: STRB_LANE_W] = {STRB_LANE_W{strb[i]}};
    end
    return (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/axi_lite_timer_if.sv
// AXI-Lite bus bundle between the core's initiator and the Timer0 responder.
interface axi_lite_timer_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);
  logic              AWVALID;
  logic              AWREADY;
  logic [ADDR_W-1:0] AWADDR;
  logic [2:0]        AWPROT;
  logic              WVALID;
  logic              WREADY;
  logic [DATA_W-1:0] WDATA;
  logic [3:0]        WSTRB;
  logic              BVALID;
  logic              BREADY;
  logic [2:0]        BRESP;
  logic              ARVALID;
  logic              ARREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic [2:0]        ARPROT;
  logic              RVALID;
  logic              RREADY;
  logic [DATA_W-1:0] RDATA;
  logic [2:0]        RRESP;

  modport master (
    output AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
           ARVALID, ARADDR, ARPROT, RREADY,
    input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );

  modport slave (
    input  AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
           ARVALID, ARADDR, ARPROT, RREADY,
    output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );
endinterface

// File: rtl/axi_lite_timer_core.sv
// Timer0 datapath: prescaler, 64-bit COUNT/CMP, sticky MATCH and the registered IRQ.
module timer_core
  import axi_lite_pkg::*;
#(
  parameter logic [REG_W-1:0] RESET_CMP = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  timer_wr_t        wr_req,
  output logic [REG_W-1:0] ctrl_word,
  output logic [REG_W-1:0] count,
  output logic [REG_W-1:0] cmp,
  output logic [REG_W-1:0] status,
  output logic             irq
);

  logic                    en_q, auto_q, irq_en_q, match_q, irq_q;
  logic [CTRL_PRESC_W-1:0] presc_q, presc_cnt_q;
  logic [REG_W-1:0]        count_q, cmp_q;

  logic tick_c, match_hit_c, wr_ctrl_c, wr_count_c, wr_cmp_c, clr_match_c;

  always_comb begin
    tick_c      = en_q && (presc_cnt_q == presc_q);
    match_hit_c = tick_c && (count_q == cmp_q);
    wr_ctrl_c   = wr_req.en && (wr_req.idx == 2'(TIMER_CTRL));
    wr_count_c  = wr_req.en && (wr_req.idx == 2'(TIMER_COUNT));
    wr_cmp_c    = wr_req.en && (wr_req.idx == 2'(TIMER_CMP));
    clr_match_c = wr_req.en && (wr_req.idx == 2'(TIMER_STATUS)) &&
                  wr_req.strb[0] && wr_req.data[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q        <= 1'b0;
      auto_q      <= 1'b0;
      irq_en_q    <= 1'b0;
      presc_q     <= '0;
      presc_cnt_q <= '0;
      count_q     <= '0;
      cmp_q       <= RESET_CMP;
      match_q     <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      // CTRL fields all live in lanes 0; a CTRL write restarts the prescaler.
      if (wr_ctrl_c) begin
        if (wr_req.strb[0]) begin
          en_q     <= wr_req.data[CTRL_EN_BIT];
          auto_q   <= wr_req.data[CTRL_AUTO_BIT];
          irq_en_q <= wr_req.data[CTRL_IRQ_EN_BIT];
          presc_q  <= wr_req.data[CTRL_PRESC_LSB +: CTRL_PRESC_W];
        end
        presc_cnt_q <= '0;
      end else if (en_q) begin
        presc_cnt_q <= tick_c ? '0 : presc_cnt_q + CTRL_PRESC_W'(1);
      end

      // Software write beats the tick; compare already used the old COUNT.
      if (wr_count_c) begin
        count_q <= lane_merge(count_q, wr_req.data, wr_req.strb);
      end else if (tick_c) begin
        count_q <= (match_hit_c && auto_q) ? '0 : count_q + REG_W'(1);
      end

      if (wr_cmp_c) begin
        cmp_q <= lane_merge(cmp_q, wr_req.data, wr_req.strb);
      end

      if (match_hit_c) begin
        match_q <= 1'b1;
      end else if (clr_match_c) begin
        match_q <= 1'b0;
      end

      irq_q <= match_q && irq_en_q;
    end
  end

  assign ctrl_word = {48'd0, presc_q, 5'd0, irq_en_q, auto_q, en_q};
  assign count     = count_q;
  assign cmp       = cmp_q;
  assign status    = {63'd0, match_q};
  assign irq       = irq_q;

endmodule

// File: rtl/axi_lite_timer.sv
// Timer0 AXI-Lite responder: write/read channel FSMs and register decode.
// Optional TIMER_PRIV_CHECK_EN rejects unprivileged (AxPROT[0]=0) accesses with SLVERR.
module axi_lite_timer
  import axi_lite_pkg::*;
#(
  parameter int unsigned      ADDR_W    = 64,
  parameter int unsigned      DATA_W    = 64,
  parameter logic [REG_W-1:0] RESET_CMP = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic             ACLK,
  input  logic             ARESET,
  axi_lite_timer_if.slave  bus,
  output logic             TimerIrq
);

  localparam int unsigned IDX_HI = (ADDR_W >= 12) ? 11 : ADDR_W - 1;

  localparam logic [1:0] WS_IDLE    = 2'd0;
  localparam logic [1:0] WS_HAVE_AW = 2'd1;
  localparam logic [1:0] WS_HAVE_W  = 2'd2;
  localparam logic [1:0] WS_RESP    = 2'd3;
  localparam logic [0:0] RS_IDLE    = 1'b0;
  localparam logic [0:0] RS_RESP    = 1'b1;

  logic [1:0]        wstate_q, wstate_d;
  logic              aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [IDX_W-1:0]  aw_idx_q, aw_idx_d;
  logic              aw_priv_q, aw_priv_d;
  logic [REG_W-1:0]  w_data_q, w_data_d;
  logic [STRB_W-1:0] w_strb_q, w_strb_d;
  logic              awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [2:0]        bresp_q, bresp_d;
  logic              wr_commit_c, wr_ok_c;

  logic [0:0]        rstate_q, rstate_d;
  logic              arready_q, arready_d, rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [2:0]        rresp_q, rresp_d;
  logic [IDX_W-1:0]  ar_idx_c;
  logic              rd_ok_c;
  logic [REG_W-1:0]  rd_mux_c;

  logic [REG_W-1:0]  ctrl_word, count, cmp, status;
  timer_wr_t         wr_req;

`ifdef TIMER_PRIV_CHECK_EN
  always_comb begin
    wr_ok_c = (aw_idx_q <= TIMER_STATUS) && aw_priv_q;
    rd_ok_c = (ar_idx_c <= TIMER_STATUS) && bus.ARPROT[0];
  end
`else
  always_comb begin
    wr_ok_c = (aw_idx_q <= TIMER_STATUS);
    rd_ok_c = (ar_idx_c <= TIMER_STATUS);
  end
`endif

  // Write channel: AW and W captured independently, committed one cycle after both held.
  always_comb begin
    wstate_d    = wstate_q;
    aw_held_d   = aw_held_q;
    w_held_d    = w_held_q;
    aw_idx_d    = aw_idx_q;
    aw_priv_d   = aw_priv_q;
    w_data_d    = w_data_q;
    w_strb_d    = w_strb_q;
    awready_d   = awready_q;
    wready_d    = wready_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    wr_commit_c = 1'b0;
    case (wstate_q)
      WS_RESP: begin
        if (bus.BREADY) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          wstate_d  = WS_IDLE;
        end
      end
      default: begin
        if (aw_held_q && w_held_q) begin
          wr_commit_c = 1'b1;
          bvalid_d    = 1'b1;
          bresp_d     = wr_ok_c ? RESP_OKAY : RESP_SLVERR;
          wstate_d    = WS_RESP;
        end else begin
          if (bus.AWVALID && awready_q) begin
            aw_held_d = 1'b1;
            aw_idx_d  = IDX_W'(bus.AWADDR[IDX_HI:3]);
            aw_priv_d = bus.AWPROT[0];
            awready_d = 1'b0;
          end
          if (bus.WVALID && wready_q) begin
            w_held_d = 1'b1;
            w_data_d = REG_W'(bus.WDATA);
            w_strb_d = bus.WSTRB;
            wready_d = 1'b0;
          end
          if (aw_held_d) begin
            wstate_d = WS_HAVE_AW;
          end else if (w_held_d) begin
            wstate_d = WS_HAVE_W;
          end
        end
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wstate_q  <= WS_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_idx_q  <= '0;
      aw_priv_q <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      wstate_q  <= wstate_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      aw_idx_q  <= aw_idx_d;
      aw_priv_q <= aw_priv_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  always_comb begin
    ar_idx_c = IDX_W'(bus.ARADDR[IDX_HI:3]);
    case (ar_idx_c[1:0])
      2'(TIMER_CTRL):  rd_mux_c = ctrl_word;
      2'(TIMER_COUNT): rd_mux_c = count;
      2'(TIMER_CMP):   rd_mux_c = cmp;
      default:         rd_mux_c = status;
    endcase
  end

  // Read channel: sample the register file at the AR handshake, hold until RREADY.
  always_comb begin
    rstate_d  = rstate_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (rstate_q)
      RS_RESP: begin
        if (bus.RREADY) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          rstate_d  = RS_IDLE;
        end
      end
      default: begin
        if (bus.ARVALID && arready_q) begin
          rvalid_d  = 1'b1;
          arready_d = 1'b0;
          rdata_d   = rd_ok_c ? DATA_W'(rd_mux_c) : '0;
          rresp_d   = rd_ok_c ? RESP_OKAY : RESP_SLVERR;
          rstate_d  = RS_RESP;
        end
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rstate_q  <= RS_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      rstate_q  <= rstate_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  always_comb begin
    wr_req.en   = wr_commit_c && wr_ok_c;
    wr_req.idx  = aw_idx_q[1:0];
    wr_req.data = w_data_q;
    wr_req.strb = w_strb_q;
  end

  timer_core #(
    .RESET_CMP (RESET_CMP)
  ) u_core (
    .clk       (ACLK),
    .rst       (ARESET),
    .wr_req    (wr_req),
    .ctrl_word (ctrl_word),
    .count     (count),
    .cmp       (cmp),
    .status    (status),
    .irq       (TimerIrq)
  );

  assign bus.AWREADY = awready_q;
  assign bus.WREADY  = wready_q;
  assign bus.BVALID  = bvalid_q;
  assign bus.BRESP   = bresp_q;
  assign bus.ARREADY = arready_q;
  assign bus.RVALID  = rvalid_q;
  assign bus.RDATA   = rdata_q;
  assign bus.RRESP   = rresp_q;

endmodule
